// File: rtl/sseg_pkg.sv
// Shared types, constants and segment table for the seven-segment scan controller.
package sseg_pkg;

   typedef enum logic [0:0] {BLANK, DRIVE} scan_state_t;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-high segments, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0111111;
         4'h1:    seg = 7'b0000110;
         4'h2:    seg = 7'b1011011;
         4'h3:    seg = 7'b1001111;
         4'h4:    seg = 7'b1100110;
         4'h5:    seg = 7'b1101101;
         4'h6:    seg = 7'b1111101;
         4'h7:    seg = 7'b0000111;
         4'h8:    seg = 7'b1111111;
         4'h9:    seg = 7'b1101111;
         4'hA:    seg = 7'b1110111;
         4'hB:    seg = 7'b1111100;
         4'hC:    seg = 7'b0111001;
         4'hD:    seg = 7'b1011110;
         4'hE:    seg = 7'b1111001;
         4'hF:    seg = 7'b1110001;
         default: seg = 7'b0000000;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1, flags the last slot cycle
// (slot_end) and the last blanking-guard cycle (guard_done).
module sseg_prescaler #(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   output logic slot_end,
   output logic guard_done
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   assign slot_end   = (cnt_q == CW'(REFRESH_DIV - 1));
   assign guard_done = (cnt_q == CW'(BLANK_CYCLES - 1));

   always_comb begin
      cnt_d = slot_end ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Define SSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int unsigned N_DIGITS     = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   hex_in,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic [N_DIGITS-1:0]     en_in,
   output logic                    pending_o,
   output logic                    frame_tick_o,
   output logic [N_DIGITS-1:0]     an_o,
   output logic [7:0]              sseg_o
);

   localparam int unsigned IW = $clog2(N_DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

   logic        slot_end;
   logic        guard_done;
   logic        commit;

   scan_state_t   state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;

   logic [N_DIGITS-1:0][3:0] act_hex_q, pend_hex_q;
   logic [N_DIGITS-1:0]      act_dp_q, act_en_q, pend_dp_q, pend_en_q;
   logic                     pend_q;

   logic [N_DIGITS-1:0] an_q, an_d;
   logic [7:0]          sseg_q, sseg_d;
   logic                show;

   sseg_prescaler #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_prescaler (
      .clk        (clk),
      .reset      (reset),
      .slot_end   (slot_end),
      .guard_done (guard_done)
   );

   // Commit point: last slot of the frame, as the index wraps to digit 0.
   assign commit = !reset && (state_q == DRIVE) && slot_end && (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         BLANK: begin
            if (guard_done) state_d = DRIVE;
         end
         DRIVE: begin
            if (slot_end) begin
               state_d = BLANK;
               idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            end
         end
         default: state_d = BLANK;
      endcase
   end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
   logic [N_DIGITS-1:0] lz_blank;
   logic                lz_above;

   // lz_above: every digit above the current one is zero or disabled.
   always_comb begin
      lz_blank = '0;
      lz_above = 1'b1;
      for (int i = N_DIGITS - 1; i > 0; i--) begin
         lz_blank[i] = lz_above && (act_hex_q[i] == 4'h0);
         lz_above    = lz_above && ((act_hex_q[i] == 4'h0) || !act_en_q[i]);
      end
   end
`endif

   always_comb begin
      an_d   = '1;
      sseg_d = SEG_OFF;
      show   = 1'b0;
      if (state_q == DRIVE) begin
         show   = act_en_q[idx_q];
         sseg_d = ~{act_dp_q[idx_q], hex_to_seg(act_hex_q[idx_q])};
`ifdef SSEG_LEADING_ZERO_BLANK_EN
         if (lz_blank[idx_q]) begin
            show = act_en_q[idx_q] & act_dp_q[idx_q];
            if (act_dp_q[idx_q]) sseg_d = 8'h7F;
         end
`endif
         if (show) an_d[idx_q] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= BLANK;
         idx_q      <= '0;
         act_hex_q  <= '0;
         act_dp_q   <= '0;
         act_en_q   <= '0;
         pend_hex_q <= '0;
         pend_dp_q  <= '0;
         pend_en_q  <= '0;
         pend_q     <= 1'b0;
         an_q       <= '1;
         sseg_q     <= SEG_OFF;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         sseg_q  <= sseg_d;
         if (commit && load) begin
            act_hex_q <= hex_in;
            act_dp_q  <= dp_in;
            act_en_q  <= en_in;
            pend_q    <= 1'b0;
         end else if (commit && pend_q) begin
            act_hex_q <= pend_hex_q;
            act_dp_q  <= pend_dp_q;
            act_en_q  <= pend_en_q;
            pend_q    <= 1'b0;
         end else if (load) begin
            pend_hex_q <= hex_in;
            pend_dp_q  <= dp_in;
            pend_en_q  <= en_in;
            pend_q     <= 1'b1;
         end
      end
   end

   assign pending_o    = pend_q;
   assign frame_tick_o = commit;
   assign an_o         = an_q;
   assign sseg_o       = sseg_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2);
// honours SSEG_LEADING_ZERO_BLANK_EN when defined.
module tb_sseg_scan_ctrl;

   localparam int ND    = 4;
   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = ND * RD;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] hex_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  en_in = '0;
   logic        pending_o;
   logic        frame_tick_o;
   logic [3:0]  an_o;
   logic [7:0]  sseg_o;

   sseg_scan_ctrl #(
      .N_DIGITS     (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .hex_in       (hex_in),
      .dp_in        (dp_in),
      .en_in        (en_in),
      .pending_o    (pending_o),
      .frame_tick_o (frame_tick_o),
      .an_o         (an_o),
      .sseg_o       (sseg_o)
   );

   always #5 clk = ~clk;

   // Reference segment table {g..a}, active-high.
   logic [6:0] seg_tab [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

   // Model: displayed image, pending image, cycles since reset release.
   logic [15:0] a_hex, p_hex;
   logic [3:0]  a_dp, a_en, p_dp, p_en;
   logic        m_pend;
   int          cyc;
   int          checks = 0;
   int          errors = 0;
   int          n_ticks;
   int          n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // Pins visible in cycle cc+1 follow from slot timing at cycle cc.
   function automatic void exp_pins(input int cc, output logic [3:0] an, output logic [7:0] sg);
      int         d;
      int         ph;
      logic [3:0] nib;
      logic       show;
      logic       lz;
      ph = cc % RD;
      d  = (cc / RD) % ND;
      an = 4'hF;
      sg = 8'hFF;
      lz = 1'b0;
      if (ph >= BC) begin
         nib  = a_hex[d*4 +: 4];
         show = a_en[d];
         sg   = ~{a_dp[d], seg_tab[nib]};
`ifdef SSEG_LEADING_ZERO_BLANK_EN
         lz = (d > 0) && (nib == 4'h0);
         for (int j = d + 1; j < ND; j++) begin
            if (a_hex[j*4 +: 4] != 4'h0 && a_en[j]) lz = 1'b0;
         end
         if (lz) begin
            show = a_en[d] & a_dp[d];
            if (a_dp[d]) sg = 8'h7F;
         end
`endif
         if (show) an[d] = 1'b0;
      end
   endfunction

   task automatic tick(input logic ld, input logic [15:0] h, input logic [3:0] dp,
                       input logic [3:0] en);
      logic [3:0] ea;
      logic [7:0] es;
      logic       commit;
      load   = ld;
      hex_in = h;
      dp_in  = dp;
      en_in  = en;
      exp_pins(cyc, ea, es);
      commit = (cyc % FRAME) == FRAME - 1;
      if (commit && ld) begin
         a_hex = h; a_dp = dp; a_en = en; m_pend = 1'b0;
      end else if (commit && m_pend) begin
         a_hex = p_hex; a_dp = p_dp; a_en = p_en; m_pend = 1'b0;
      end else if (ld) begin
         p_hex = h; p_dp = dp; p_en = en; m_pend = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      load = 1'b0;
      chk("an", 32'(an_o), 32'(ea));
      chk("sseg", 32'(sseg_o), 32'(es));
      chk("pending", 32'(pending_o), 32'(m_pend));
      chk("frame_tick", 32'(frame_tick_o), 32'((cyc % FRAME) == FRAME - 1));
      if (frame_tick_o) n_ticks++;
   endtask

   task automatic idle_until(input int t);
      while (cyc < t) tick(1'b0, 16'h0, 4'h0, 4'h0);
   endtask

   task automatic run_to_phase(input int p);
      while (cyc % FRAME != p) tick(1'b0, 16'h0, 4'h0, 4'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      load  = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_an", 32'(an_o), 32'hF);
      chk("rst_sseg", 32'(sseg_o), 32'hFF);
      chk("rst_pending", 32'(pending_o), 32'h0);
      chk("rst_frame_tick", 32'(frame_tick_o), 32'h0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      a_hex  = '0; a_dp = '0; a_en = '0;
      p_hex  = '0; p_dp = '0; p_en = '0;
      m_pend = 1'b0;
      cyc    = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      cyc = 0;
      do_reset();

      // Idle: all dark, frame tick every 32 cycles.
      n_ticks = 0;
      idle_until(64);
      chk("idle_tick_count", 32'(n_ticks), 32'd2);

      // Basic image 1234.
      tick(1'b1, 16'h1234, 4'h0, 4'hF);
      idle_until(99);
      chk("d0_an", 32'(an_o), 32'b1110);
      chk("d0_sseg", 32'(sseg_o), 32'h99);
      idle_until(107);
      chk("d1_an", 32'(an_o), 32'b1101);
      chk("d1_sseg", 32'(sseg_o), 32'hB0);

      // Last load before commit wins.
      idle_until(110);
      tick(1'b1, 16'hAAAA, 4'h0, 4'hF);
      tick(1'b1, 16'h00F0, 4'h0, 4'hF);
      idle_until(140);
      chk("lastwin_an", 32'(an_o), 32'b1101);
      chk("lastwin_sseg", 32'(sseg_o), 32'h8E);

      // Load exactly on the commit cycle, found via frame_tick_o.
      n = 0;
      while (frame_tick_o !== 1'b1 && n < 2 * FRAME) begin
         tick(1'b0, 16'h0, 4'h0, 4'h0);
         n++;
      end
      chk("commit_found", 32'(frame_tick_o), 32'd1);
      tick(1'b1, 16'h5555, 4'h0, 4'hF);
      chk("commit_load_pending", 32'(pending_o), 32'd0);
      idle_until(163);
      chk("commit_load_an", 32'(an_o), 32'b1110);
      chk("commit_load_sseg", 32'(sseg_o), 32'h92);

      // Disabled digits 1 and 3, dp on digit 1.
      idle_until(170);
      tick(1'b1, 16'($urandom), 4'b0010, 4'b0101);
      idle_until(197);
      chk("en_d0_an", 32'(an_o), 32'b1110);
      idle_until(205);
      chk("dis_d1_an", 32'(an_o), 32'hF);
      idle_until(221);
      chk("dis_d3_an", 32'(an_o), 32'hF);

      // Randomized loads against the model.
      for (int i = 0; i < 300; i++) begin
         tick($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
      end

      // Reset mid-DRIVE on digit 2 with a load pending.
      run_to_phase(5);
      tick(1'b1, 16'h9876, 4'h0, 4'hF);
      run_to_phase(0);
      run_to_phase(10);
      tick(1'b1, 16'h4321, 4'h0, 4'hF);
      run_to_phase(20);
      chk("pre_rst_an", 32'(an_o), 32'b1011);
      chk("pre_rst_sseg", 32'(sseg_o), 32'h80);
      chk("pre_rst_pending", 32'(pending_o), 32'd1);
      do_reset();

      // Image 0007: leading zeros only blanked with the option built in.
      tick(1'b1, 16'h0007, 4'h0, 4'hF);
      idle_until(35);
      chk("z7_d0_an", 32'(an_o), 32'b1110);
      chk("z7_d0_sseg", 32'(sseg_o), 32'hF8);
      idle_until(43);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      chk("z7_d1_an", 32'(an_o), 32'hF);
`else
      chk("z7_d1_an", 32'(an_o), 32'b1101);
`endif
      chk("z7_d1_sseg", 32'(sseg_o), 32'hC0);
      idle_until(96);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Holds a double-buffered hex/decimal-point/enable image and steps one active digit per refresh slot.
- Inserts a blanking guard between digits to suppress ghosting.
- Decodes the selected nibble to segments internally.
- Sits between user logic (debounced switch counters, etc.) and board anode/segment pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= 4).
- BLANK_CYCLES, 16, all-off guard cycles at the start of each slot (1 .. REFRESH_DIV-2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe; captures hex_in/dp_in/en_in into the pending buffer
- hex_in  in  4*N_DIGITS  digit nibbles; digit i = hex_in[4i+3:4i], digit 0 = rightmost
- dp_in  in  N_DIGITS  decimal point per digit, 1 = lit
- en_in  in  N_DIGITS  digit enable, 1 = shown
- pending_o  out  1  pending buffer holds data not yet committed
- frame_tick_o  out  1  one-cycle pulse at each frame commit point
- an_o  out  N_DIGITS  anode selects, active-low
- sseg_o  out  8  {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (synchronous, active-high, mid-operation included) forces:
  - an_o = all 1s, sseg_o = 8'hFF, pending_o = 0, frame_tick_o = 0.
  - Prescaler = 0, digit index = 0, state = BLANK.
  - Pending and active buffers cleared (en = 0, hex = 0, dp = 0).
- Prescaler counts 0..REFRESH_DIV-1 and wraps. The wrap cycle is slot_end.
- FSM, 2 states:
  - BLANK: an_o all 1s, sseg_o = 8'hFF. Leave to DRIVE when prescaler == BLANK_CYCLES-1.
  - DRIVE: an_o[idx] = 0 only if active en[idx] = 1, otherwise all 1s. sseg_o = ~{dp[idx], seg(hex[idx])}.
  - On slot_end in DRIVE: idx <= (idx == N_DIGITS-1) ? 0 : idx+1, next state BLANK.
- Outputs are registered: pins change the cycle after the state or idx change.
- Frame commit: occurs on the slot_end where idx wraps N_DIGITS-1 -> 0.
  - frame_tick_o pulses high for that one cycle.
  - If pending_o = 1: active <= pending, pending_o <= 0.
- Load rules:
  - load copies inputs to the pending buffer and sets pending_o = 1 next cycle.
  - load while pending_o = 1: pending is overwritten; last load wins.
  - load on the commit cycle: the inputs go directly to active; pending_o = 0 afterwards.
- Decode, active-high before inversion, bit order g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Disabled digit: the slot still elapses, so scan timing stays uniform. The anode stays off, which also suppresses dp.
- Frame period = N_DIGITS*REFRESH_DIV cycles, exactly.

Optional Feature:
- Macro: SSEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit i > 0 whose nibble is 0 and whose higher-order digits are all 0 or disabled is shown as if en = 0.
  - Exception: if dp[i] = 1, the anode is driven with segments off and dp lit.
  - Digit 0 is never blanked.
  - The condition is computed from the active buffer only.
- Undefined: zeros are displayed normally; no extra logic.

Decomposition:
- Package sseg_pkg:
  - typedef scan_state_t enum {BLANK, DRIVE}.
  - localparam SEG_OFF = 8'hFF.
  - Function for the 16-entry hex-to-segment constant table.
- Sub-module sseg_prescaler: REFRESH_DIV counter. Outputs slot_end and guard_done, driven by the BLANK_CYCLES compare.
- The FSM, buffers and decode stay in sseg_scan_ctrl.

Test Plan (bench uses N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, then idle 64 cycles:
  - an_o = 4'b1111, sseg_o = 8'hFF throughout.
  - frame_tick_o pulses every 32 cycles.
- load hex_in=16'h1234, en_in=4'hF, dp_in=0:
  - pending_o = 1 until the next commit.
  - After commit, each slot shows 2 blank cycles, then 6 drive cycles.
  - Slot sequence: an=1110 sseg=~8'b0_1100110, an=1101 ~8'b0_1001111, an=1011 ~8'b0_1011011, an=0111 ~8'b0_0000110.
- Two loads before commit (16'hAAAA, then 16'h00F0):
  - Only 00F0 is displayed.
  - Digit 1 shows sseg=~8'b0_1110001.
- load asserted exactly on the commit cycle with 16'h5555:
  - pending_o stays 0.
  - Digit 0 shows ~8'b0_1101101 in the very next DRIVE.
- en_in=4'b0101, dp_in=4'b0010: digits 1 and 3 keep an_o all 1s during their slots; the dp is not visible.
- Assert reset mid-DRIVE on digit 2: the next cycle gives an_o=1111, sseg_o=FF, pending_o=0. With SSEG_LEADING_ZERO_BLANK_EN, load 16'h0007 lights only digit 0.
